alex_axilite_wr_q: RTL and testbench

//  AXI-Lite write slave to register-bus bridge with independent AW/W/B queues.

---
 rtl/alex_axilite_wr_q.sv | 208 ++++++++++++++++++++
 tb/tb_alex_axilite_wr_q.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alex_axilite_wr_q.sv
// AXI-Lite write slave feeding a single-beat register bus. AW, W and B each sit in
// their own circular queue; one register write is in flight at a time, guarded by an
// address-window check (DECERR) and an ack timeout (SLVERR).
module alex_axilite_wr_q #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 40,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           AW_DEPTH   = 4,
  parameter int unsigned           W_DEPTH    = 4,
  parameter int unsigned           B_DEPTH    = 4,
  parameter int unsigned           TIMEOUT    = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'(1024)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack,
  output logic [7:0]            err_count
);

  localparam int unsigned AwPw   = $clog2(AW_DEPTH);
  localparam int unsigned WPw    = $clog2(W_DEPTH);
  localparam int unsigned BPw    = $clog2(B_DEPTH);
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  logic unused_prot;
  assign unused_prot = ^s_axil_awprot;

  // Queue storage and pointers; pointers carry one wrap bit to tell full from empty.
  logic [ADDR_WIDTH-1:0]            aw_mem_q [AW_DEPTH];
  logic [STRB_WIDTH+DATA_WIDTH-1:0] w_mem_q  [W_DEPTH];
  logic [1:0]                       b_mem_q  [B_DEPTH];

  logic [AwPw:0] aw_wptr_q, aw_wptr_d, aw_rptr_q, aw_rptr_d;
  logic [WPw:0]  w_wptr_q, w_wptr_d, w_rptr_q, w_rptr_d;
  logic [BPw:0]  b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;

  logic aw_empty, aw_full, w_empty, w_full, b_empty, b_full;
  logic aw_push, aw_pop, w_push, w_pop, b_push, b_pop;
  logic [1:0] b_push_resp;

  logic [ADDR_WIDTH-1:0] aw_head, aw_off;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [STRB_WIDTH-1:0] w_head_strb;
  logic                  aw_in_range;

  state_e                state_q, state_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [7:0]            err_q, err_d;

  assign aw_empty = (aw_wptr_q == aw_rptr_q);
  assign aw_full  = (aw_wptr_q == {~aw_rptr_q[AwPw], aw_rptr_q[AwPw-1:0]});
  assign w_empty  = (w_wptr_q == w_rptr_q);
  assign w_full   = (w_wptr_q == {~w_rptr_q[WPw], w_rptr_q[WPw-1:0]});
  assign b_empty  = (b_wptr_q == b_rptr_q);
  assign b_full   = (b_wptr_q == {~b_rptr_q[BPw], b_rptr_q[BPw-1:0]});

  assign s_axil_awready = !aw_full;
  assign s_axil_wready  = !w_full;
  assign s_axil_bvalid  = !b_empty;
  assign s_axil_bresp   = b_mem_q[b_rptr_q[BPw-1:0]];

  assign aw_push = s_axil_awvalid && !aw_full;
  assign w_push  = s_axil_wvalid && !w_full;
  assign b_pop   = !b_empty && s_axil_bready;

  assign aw_head                    = aw_mem_q[aw_rptr_q[AwPw-1:0]];
  assign {w_head_strb, w_head_data} = w_mem_q[w_rptr_q[WPw-1:0]];

  // Wrapping subtraction makes addresses below the base look huge, so one compare suffices.
  assign aw_off      = aw_head - ADDR_BASE;
  assign aw_in_range = aw_off < ADDR_SPAN;

  assign aw_wptr_d = aw_push ? aw_wptr_q + (AwPw+1)'(1) : aw_wptr_q;
  assign aw_rptr_d = aw_pop  ? aw_rptr_q + (AwPw+1)'(1) : aw_rptr_q;
  assign w_wptr_d  = w_push  ? w_wptr_q + (WPw+1)'(1) : w_wptr_q;
  assign w_rptr_d  = w_pop   ? w_rptr_q + (WPw+1)'(1) : w_rptr_q;
  assign b_wptr_d  = b_push  ? b_wptr_q + (BPw+1)'(1) : b_wptr_q;
  assign b_rptr_d  = b_pop   ? b_rptr_q + (BPw+1)'(1) : b_rptr_q;

  // Queue payload storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (aw_push) aw_mem_q[aw_wptr_q[AwPw-1:0]] <= s_axil_awaddr;
    if (w_push)  w_mem_q[w_wptr_q[WPw-1:0]]    <= {s_axil_wstrb, s_axil_wdata};
    if (b_push)  b_mem_q[b_wptr_q[BPw-1:0]]    <= b_push_resp;
  end

  // Next-state: pair queue heads, range-check, then drive the register bus until ack/timeout.
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    timer_d     = timer_q;
    aw_pop      = 1'b0;
    w_pop       = 1'b0;
    b_push      = 1'b0;
    b_push_resp = 2'b00;
    unique case (state_q)
      StIdle: begin
        // !b_full here reserves the B slot this write will eventually fill.
        if (!aw_empty && !w_empty && !b_full) begin
          aw_pop = 1'b1;
          w_pop  = 1'b1;
          if (aw_in_range) begin
            state_d = StIssue;
            en_d    = 1'b1;
            addr_d  = aw_head;
            data_d  = w_head_data;
            strb_d  = w_head_strb;
            timer_d = TimerLoad;
          end else begin
            b_push      = 1'b1;
            b_push_resp = 2'b11;
          end
        end
      end
      StIssue: begin
        if (reg_wr_ack) begin
          b_push      = 1'b1;
          b_push_resp = 2'b00;
          state_d     = StIdle;
          en_d        = 1'b0;
        end else if (!reg_wr_wait) begin
          if (timer_q == '0) begin
            b_push      = 1'b1;
            b_push_resp = 2'b10;
            state_d     = StIdle;
            en_d        = 1'b0;
          end else begin
            timer_d = timer_q - TimerW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating error counter.
  always_comb begin
    err_d = err_q;
    if (b_push && (b_push_resp != 2'b00) && (err_q != 8'hff)) err_d = err_q + 8'd1;
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      timer_q   <= '0;
      err_q     <= '0;
      aw_wptr_q <= '0;
      aw_rptr_q <= '0;
      w_wptr_q  <= '0;
      w_rptr_q  <= '0;
      b_wptr_q  <= '0;
      b_rptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      aw_wptr_q <= aw_wptr_d;
      aw_rptr_q <= aw_rptr_d;
      w_wptr_q  <= w_wptr_d;
      w_rptr_q  <= w_rptr_d;
      b_wptr_q  <= b_wptr_d;
      b_rptr_q  <= b_rptr_d;
    end
  end

  assign reg_wr_en   = en_q;
  assign reg_wr_addr = addr_q;
  assign reg_wr_data = data_q;
  assign reg_wr_strb = strb_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_alex_axilite_wr_q.sv
// Scoreboard bench for alex_axilite_wr_q: issued writes push expected register-bus
// transfers and B responses; a register-file responder and a B monitor pop and compare.
module tb_alex_axilite_wr_q;

  localparam longint Base    = 0;
  localparam longint Span    = 1024;
  localparam int     Timeout = 16;

  typedef struct {
    logic [39:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;     // ack after this many en cycles; -1 = never
    int          waits;     // reg_wr_wait held for the first this-many en cycles
    logic [1:0]  resp;
    int          en_cycles;
  } txn_t;

  logic        clk, rstn;
  logic [39:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid, s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid, s_axil_bready;
  logic [39:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_wr_wait, reg_wr_ack;
  logic [7:0]  err_count;

  txn_t       aw_q[$];
  txn_t       w_q[$];
  txn_t       reg_exp_q[$];
  logic [1:0] b_exp_q[$];
  txn_t       w_hold, aw_cur, w_cur, rsp_cur;
  int         exp_err;
  int         checks, errors;
  int         bready_mode;  // 0 low, 1 high, 2 random
  bit         rand_gap;

  alex_axilite_wr_q dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awprot (s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_strb   (reg_wr_strb),
    .reg_wr_en     (reg_wr_en),
    .reg_wr_wait   (reg_wr_wait),
    .reg_wr_ack    (reg_wr_ack),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: window check, then ack-vs-timeout race decided from the plan.
  task automatic issue(input logic [39:0] addr, input logic [31:0] data, input int delay,
                       input int waits, input bit send_w);
    txn_t   t;
    longint a;
    a       = longint'({24'b0, addr});
    t.addr  = addr;
    t.data  = data;
    t.strb  = 4'($urandom);
    t.delay = delay;
    t.waits = waits;
    if (!(a >= Base && a < Base + Span)) begin
      t.resp = 2'b11;
      t.en_cycles = 0;
    end else if (delay >= 0 && delay <= Timeout + waits - 1) begin
      t.resp = 2'b00;
      t.en_cycles = delay + 1;
    end else begin
      t.resp = 2'b10;
      t.en_cycles = Timeout + waits;
    end
    if (t.resp != 2'b11) reg_exp_q.push_back(t);
    b_exp_q.push_back(t.resp);
    if (t.resp != 2'b00 && exp_err < 255) exp_err++;
    aw_q.push_back(t);
    if (send_w) w_q.push_back(t);
    else w_hold = t;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((aw_q.size() != 0 || w_q.size() != 0 || reg_exp_q.size() != 0 ||
            b_exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 5000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // AW driver
  initial begin
    int n;
    s_axil_awvalid = 1'b0;
    s_axil_awaddr  = '0;
    forever begin
      @(negedge clk);
      if (aw_q.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
        aw_cur         = aw_q.pop_front();
        s_axil_awaddr  = aw_cur.addr;
        s_axil_awvalid = 1'b1;
        n = 0;
        while (!s_axil_awready && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("aw_accept_timeout", 64'(n < 3000), 64'd1);
        @(posedge clk);
        #1 s_axil_awvalid = 1'b0;
      end
    end
  end

  // W driver
  initial begin
    int n;
    s_axil_wvalid = 1'b0;
    s_axil_wdata  = '0;
    s_axil_wstrb  = '0;
    forever begin
      @(negedge clk);
      if (w_q.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
        w_cur         = w_q.pop_front();
        s_axil_wdata  = w_cur.data;
        s_axil_wstrb  = w_cur.strb;
        s_axil_wvalid = 1'b1;
        n = 0;
        while (!s_axil_wready && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("w_accept_timeout", 64'(n < 3000), 64'd1);
        @(posedge clk);
        #1 s_axil_wvalid = 1'b0;
      end
    end
  end

  // bready driver, updated just after the rising edge
  initial begin
    s_axil_bready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bready_mode)
        0:       s_axil_bready = 1'b0;
        1:       s_axil_bready = 1'b1;
        default: s_axil_bready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // B monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rstn && s_axil_bvalid && s_axil_bready) begin
        if (b_exp_q.size() == 0) begin
          chk("b_unexpected", 64'(s_axil_bvalid), 64'd0);
        end else begin
          e = b_exp_q.pop_front();
          chk("bresp", 64'(s_axil_bresp), 64'(e));
        end
      end
    end
  end

  // Register-file responder: checks each transfer and its en duration
  initial begin
    int cyc;
    reg_wr_ack  = 1'b0;
    reg_wr_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && reg_wr_en) begin
        if (reg_exp_q.size() == 0) begin
          chk("en_unexpected", 64'(reg_wr_en), 64'd0);
          rsp_cur.delay = 0;
          rsp_cur.waits = 0;
          rsp_cur.en_cycles = 1;
        end else begin
          rsp_cur = reg_exp_q.pop_front();
          chk("reg_addr", 64'(reg_wr_addr), 64'(rsp_cur.addr));
          chk("reg_data", 64'(reg_wr_data), 64'(rsp_cur.data));
          chk("reg_strb", 64'(reg_wr_strb), 64'(rsp_cur.strb));
        end
        cyc = 0;
        while (reg_wr_en && rstn && cyc < 200) begin
          reg_wr_wait = (cyc < rsp_cur.waits);
          reg_wr_ack  = (rsp_cur.delay >= 0 && cyc == rsp_cur.delay);
          @(negedge clk);
          cyc++;
        end
        reg_wr_ack  = 1'b0;
        reg_wr_wait = 1'b0;
        if (rstn) chk("en_cycles", 64'(cyc), 64'(rsp_cur.en_cycles));
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [39:0] a;
    int d, w;
    checks = 0;
    errors = 0;
    exp_err = 0;
    bready_mode = 1;
    rand_gap = 1'b0;
    s_axil_awprot = 3'b000;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bvalid", 64'(s_axil_bvalid), 64'd0);
    chk("rst_en", 64'(reg_wr_en), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(s_axil_awready), 64'd1);
    chk("rst_wready", 64'(s_axil_wready), 64'd1);

    // AW first, W three cycles later, immediate ack
    issue(40'h10, 32'hDEADBEEF, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    w_q.push_back(w_hold);
    drain();

    // B backpressure: four writes fill B, four more fill AW/W
    bready_mode = 0;
    for (int i = 0; i < 4; i++) issue(40'h40 + 40'(4 * i), $urandom, 0, 0, 1'b1);
    n = 0;
    while ((reg_exp_q.size() != 0 || aw_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("bp_bvalid_held", 64'(s_axil_bvalid), 64'd1);
    for (int i = 0; i < 4; i++) issue(40'h80 + 40'(4 * i), $urandom, 0, 0, 1'b1);
    repeat (20) @(negedge clk);
    chk("bp_awready_low", 64'(s_axil_awready), 64'd0);
    chk("bp_wready_low", 64'(s_axil_wready), 64'd0);
    bready_mode = 1;
    drain();
    chk("err_after_okays", 64'(err_count), 64'(exp_err));

    // Out-of-window address
    issue(40'h400, $urandom, 0, 0, 1'b1);
    drain();
    chk("err_decerr", 64'(err_count), 64'(exp_err));

    // Timeouts, plain and with a 10-cycle wait stall
    issue(40'h20, $urandom, -1, 0, 1'b1);
    issue(40'h24, $urandom, -1, 10, 1'b1);
    drain();
    chk("err_slverr", 64'(err_count), 64'(exp_err));

    // Reset while a write is in flight
    issue(40'h30, $urandom, -1, 0, 1'b1);
    n = 0;
    while (!reg_wr_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", 64'(reg_wr_en), 64'd1);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_en", 64'(reg_wr_en), 64'd0);
    chk("rst_mid_bvalid", 64'(s_axil_bvalid), 64'd0);
    chk("rst_mid_err", 64'(err_count), 64'd0);
    reg_exp_q.delete();
    b_exp_q.delete();
    exp_err = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(40'h34, $urandom, 1, 0, 1'b1);
    drain();
    chk("err_post_reset", 64'(err_count), 64'(exp_err));

    // Randomised traffic
    rand_gap = 1'b1;
    bready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 40'h400;
        1:       a = 40'h3FC;
        2:       a = {8'hFF, 32'($urandom)};
        default: a = 40'($urandom_range(0, 255)) << 2;
      endcase
      if ($urandom_range(0, 7) == 0) d = -1;
      else if ($urandom_range(0, 3) == 0) d = int'($urandom_range(10, 24));
      else d = int'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0;
      issue(a, $urandom, d, w, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bready_mode = 1;
    drain();
    rand_gap = 1'b0;
    chk("err_random", 64'(err_count), 64'(exp_err));

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) issue(40'h800 + 40'(4 * i), $urandom, 0, 0, 1'b1);
    drain();
    chk("err_saturate", 64'(err_count), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
